// File: rtl/lpm_pkg.sv
// Shared constants and helpers for the longest-prefix-match lookup pipeline.
package lpm_pkg;

    localparam int PASS_W    = 8;
    localparam int SLICE_MAX = 256;

    // The leaf flag sits just above the result/child field of a memory word
    function automatic int leaf_idx(input int addr_w);
        return addr_w;
    endfunction

    // Stride-wide slice number idx of a key, counted from the MSB end, zero-extended
    function automatic logic [SLICE_MAX-1:0] key_slice(
        input logic [SLICE_MAX-1:0] key,
        input int                   key_w,
        input int                   stride,
        input int                   idx
    );
        logic [SLICE_MAX-1:0] mask;
        mask = (SLICE_MAX'(1'b1) << stride) - SLICE_MAX'(1'b1);
        return (key >> (key_w - (idx + 32'sd1) * stride)) & mask;
    endfunction

endpackage

// File: rtl/lpm_fifo.sv
// Registered FIFO; the caller may enqueue into a full FIFO when it dequeues on the same edge.
module lpm_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             enq__ENA,
    input  logic [WIDTH-1:0] enq_v,
    output logic             enq__RDY,
    input  logic             deq__ENA,
    output logic             deq__RDY,
    output logic [WIDTH-1:0] first
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   count_r;

    assign enq__RDY = (count_r != (PTR_W + 1)'(DEPTH));
    assign deq__RDY = (count_r != '0);
    assign first    = mem_r[rd_ptr_r];

    // Storage array, no reset needed since occupancy gates every read
    always_ff @(posedge CLK) begin
        if (enq__ENA) begin
            mem_r[wr_ptr_r] <= enq_v;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq__ENA) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (deq__ENA) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            count_r <= count_r + {{PTR_W{1'b0}}, enq__ENA} - {{PTR_W{1'b0}}, deq__ENA};
        end
    end

endmodule

// File: rtl/lpm_pipe.sv
// Multi-pass trie-walk LPM engine: requests enter via inQ, recirculate through the
// in-flight FIFO one stride per memory access, and leave through outQ.
module lpm_pipe
    import lpm_pkg::*;
#(
    parameter int TAG_W    = 32,
    parameter int KEY_W    = 32,
    parameter int ADDR_W   = 16,
    parameter int STRIDE   = 8,
    parameter int MAX_PASS = 4,
    parameter int DEPTH    = 4
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              say__ENA,
    input  logic [TAG_W-1:0]  say_meth,
    input  logic [KEY_W-1:0]  say_v,
    output logic              say__RDY,
    output logic              indication_heard__ENA,
    output logic [TAG_W-1:0]  indication_heard_meth,
    output logic [ADDR_W-1:0] indication_heard_v,
    output logic              indication_heard_miss,
    input  logic              indication_heard__RDY,
    output logic              mem_req__ENA,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req__RDY,
    input  logic              mem_resp__ENA,
    input  logic [ADDR_W:0]   mem_resp_data,
    output logic              mem_resp__RDY,
    output logic [31:0]       done_count
);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [KEY_W-1:0] key;
    } req_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [KEY_W-1:0]  key;
        logic [PASS_W-1:0] pass;
    } ctx_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] value;
        logic              miss;
    } res_t;

    req_t inq_in_s, inq_head_s;
    ctx_t fl_in_s, fl_head_s;
    res_t oq_in_s, oq_head_s;
    logic inq_rdy_s, inq_valid_s, inq_push_s;
    logic fl_rdy_s, fl_valid_s, fl_push_s;
    logic oq_rdy_s, oq_valid_s;
    logic resp_leaf_s, head_exit_s, resp_rdy_s, resp_fire_s;
    logic exit_s, recirc_s, enter_s, heard_fire_s;
    logic [PASS_W-1:0] next_pass_s;
    logic [ADDR_W-1:0] req_addr_s;
    logic [31:0] done_count_r;

    assign inq_in_s   = '{tag: say_meth, key: say_v};
    assign inq_push_s = say__ENA && say__RDY;
    assign fl_push_s  = enter_s || recirc_s;

    lpm_fifo #(.WIDTH($bits(req_t)), .DEPTH(DEPTH)) u_inq (
        .CLK(CLK), .RST(RST),
        .enq__ENA(inq_push_s), .enq_v(inq_in_s), .enq__RDY(inq_rdy_s),
        .deq__ENA(enter_s), .deq__RDY(inq_valid_s), .first(inq_head_s)
    );

    lpm_fifo #(.WIDTH($bits(ctx_t)), .DEPTH(DEPTH)) u_flight (
        .CLK(CLK), .RST(RST),
        .enq__ENA(fl_push_s), .enq_v(fl_in_s), .enq__RDY(fl_rdy_s),
        .deq__ENA(resp_fire_s), .deq__RDY(fl_valid_s), .first(fl_head_s)
    );

    lpm_fifo #(.WIDTH($bits(res_t)), .DEPTH(DEPTH)) u_outq (
        .CLK(CLK), .RST(RST),
        .enq__ENA(exit_s), .enq_v(oq_in_s), .enq__RDY(oq_rdy_s),
        .deq__ENA(heard_fire_s), .deq__RDY(oq_valid_s), .first(oq_head_s)
    );

    // Handshakes, recirc-over-enter arbitration of the memory port, next address
    always_comb begin
        resp_leaf_s = mem_resp_data[leaf_idx(ADDR_W)];
        head_exit_s = resp_leaf_s || (fl_head_s.pass == PASS_W'(MAX_PASS - 1));
        if (!RST && fl_valid_s) begin
            resp_rdy_s = head_exit_s ? oq_rdy_s : mem_req__RDY;
        end else begin
            resp_rdy_s = 1'b0;
        end
        resp_fire_s  = mem_resp__ENA && resp_rdy_s;
        exit_s       = resp_fire_s && head_exit_s;
        recirc_s     = resp_fire_s && !head_exit_s;
        enter_s      = !RST && inq_valid_s && fl_rdy_s && mem_req__RDY && !recirc_s;
        next_pass_s  = fl_head_s.pass + PASS_W'(1'b1);
        heard_fire_s = !RST && oq_valid_s && indication_heard__RDY;
        if (recirc_s) begin
            req_addr_s = mem_resp_data[ADDR_W-1:0]
                       + ADDR_W'(key_slice(SLICE_MAX'(fl_head_s.key), KEY_W, STRIDE, int'(next_pass_s)));
            fl_in_s    = '{tag: fl_head_s.tag, key: fl_head_s.key, pass: next_pass_s};
        end else if (enter_s) begin
            req_addr_s = ADDR_W'(key_slice(SLICE_MAX'(inq_head_s.key), KEY_W, STRIDE, 32'sd0));
            fl_in_s    = '{tag: inq_head_s.tag, key: inq_head_s.key, pass: '0};
        end else begin
            req_addr_s = '0;
            fl_in_s    = '0;
        end
        oq_in_s.tag   = fl_head_s.tag;
        oq_in_s.value = resp_leaf_s ? mem_resp_data[ADDR_W-1:0] : '0;
        oq_in_s.miss  = !resp_leaf_s;
    end

    assign say__RDY              = !RST && inq_rdy_s;
    assign mem_req__ENA          = enter_s || recirc_s;
    assign mem_req_addr          = req_addr_s;
    assign mem_resp__RDY         = resp_rdy_s;
    assign indication_heard__ENA = heard_fire_s;
    assign indication_heard_meth = (!RST && oq_valid_s) ? oq_head_s.tag   : '0;
    assign indication_heard_v    = (!RST && oq_valid_s) ? oq_head_s.value : '0;
    assign indication_heard_miss = (!RST && oq_valid_s) ? oq_head_s.miss  : 1'b0;
    assign done_count            = RST ? 32'd0 : done_count_r;

    // Completed-lookup counter, wraps naturally
    always_ff @(posedge CLK) begin
        if (RST) begin
            done_count_r <= 32'd0;
        end else if (exit_s) begin
            done_count_r <= done_count_r + 32'd1;
        end
    end

endmodule

// File: tb/tb_lpm_pipe.sv
// Self-checking bench for lpm_pipe: directed table, corner sequences and a random run
// scored against a pass-by-pass trie-walk model over the bench-owned memory.
module tb_lpm_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic        say_ena, say_rdy;
    logic [31:0] say_meth, say_v;
    logic        heard_ena, heard_rdy, heard_miss;
    logic [31:0] heard_meth;
    logic [15:0] heard_v;
    logic        mreq_ena, mreq_rdy;
    logic [15:0] mreq_addr;
    logic        mresp_ena, mresp_rdy;
    logic [16:0] mresp_data;
    logic [31:0] done_count;

    lpm_pipe dut (
        .CLK(CLK), .RST(RST),
        .say__ENA(say_ena), .say_meth(say_meth), .say_v(say_v), .say__RDY(say_rdy),
        .indication_heard__ENA(heard_ena), .indication_heard_meth(heard_meth),
        .indication_heard_v(heard_v), .indication_heard_miss(heard_miss),
        .indication_heard__RDY(heard_rdy),
        .mem_req__ENA(mreq_ena), .mem_req_addr(mreq_addr), .mem_req__RDY(mreq_rdy),
        .mem_resp__ENA(mresp_ena), .mem_resp_data(mresp_data), .mem_resp__RDY(mresp_rdy),
        .done_count(done_count)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { logic [15:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] tag; logic [15:0] v; logic miss; int cyc; } got_t;
    typedef struct { logic [31:0] tag; logic [31:0] key; logic [15:0] v; logic miss; int reqs; } vec_t;

    logic [16:0] mem [0:65535];
    pend_t       pend_q[$];
    got_t        got_q[$];
    logic [15:0] req_addr_q[$];
    int          req_cyc_q[$];
    int lat_min = 1, lat_max = 1, mreq_pct = 100, heard_mode = 1;
    int last_due = 0, due_v, resp_fires = 0;
    bit flush_req = 1'b0;
    int n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // Trie walk straight from the lookup rules; returns {miss, value}
    function automatic logic [16:0] model(input logic [31:0] key);
        logic [15:0] addr;
        logic [16:0] d;
        addr = {8'h00, key[31:24]};
        for (int p = 0; p < 4; p++) begin
            d = mem[addr];
            if (d[16]) return {1'b0, d[15:0]};
            if (p == 3) return {1'b1, 16'h0000};
            addr = d[15:0] + {8'h00, key[31 - 8 * (p + 1) -: 8]};
        end
        return 17'h0;
    endfunction

    // In-order memory with configurable latency, plus output monitor and ready drivers
    initial begin
        mresp_ena = 1'b0; mresp_data = '0; mreq_rdy = 1'b1;
        forever begin
            @(negedge CLK);
            if (mreq_ena && mreq_rdy) begin
                due_v = cyc + int'($urandom_range(lat_max, lat_min));
                if (due_v < last_due) due_v = last_due;
                last_due = due_v;
                pend_q.push_back('{addr: mreq_addr, due: due_v});
                req_addr_q.push_back(mreq_addr);
                req_cyc_q.push_back(cyc);
            end
            if (mresp_ena && mresp_rdy) begin
                pend_q.delete(0);
                resp_fires++;
            end
            if (heard_ena && heard_rdy)
                got_q.push_back('{tag: heard_meth, v: heard_v, miss: heard_miss, cyc: cyc});
            @(posedge CLK); #1;
            if (flush_req) begin pend_q.delete(); flush_req = 1'b0; end
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                mresp_ena = 1'b1; mresp_data = mem[pend_q[0].addr];
            end else begin
                mresp_ena = 1'b0; mresp_data = '0;
            end
            mreq_rdy = (int'($urandom_range(99, 0)) < mreq_pct);
            case (heard_mode)
                0:       heard_rdy = 1'b0;
                1:       heard_rdy = 1'b1;
                default: heard_rdy = (int'($urandom_range(99, 0)) < 70);
            endcase
        end
    end

    task automatic step(); @(posedge CLK); #1; endtask

    task automatic try_send(input logic [31:0] tag, input logic [31:0] key, input int bound, output bit ok);
        int n = 0;
        say_meth = tag; say_v = key; say_ena = 1'b1;
        @(negedge CLK);
        while (!say_rdy && n < bound) begin @(negedge CLK); n++; end
        ok = say_rdy;
        @(posedge CLK); #1;
        say_ena = 1'b0;
    endtask

    task automatic send(input logic [31:0] tag, input logic [31:0] key, output int acc_cyc);
        bit ok;
        try_send(tag, key, 500, ok);
        acc_cyc = cyc - 1;
        chk("say_accepted", 64'(ok), 64'd1);
    endtask

    task automatic wait_heard(input int n, input string name);
        int t = 0;
        while (got_q.size() < n && t < 3000) begin step(); t++; end
        chk({name, "_arrival"}, 64'(got_q.size() >= n), 64'd1);
    endtask

    task automatic check_done(input string name, input int exp);
        @(negedge CLK);
        chk(name, 64'(done_count), 64'(exp));
        step();
    endtask

    initial begin
        vec_t tbl[7];
        got_t r;
        int acc, base, accepted, late_acc, fires0;
        bit ok, saw_late;
        logic [16:0] exp_by_tag [logic [31:0]];

        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        got_t r;
        int acc, base, accepted, late_acc, fires0;
        bit ok, saw_late;
        logic [16:0] exp_by_tag [logic [31:0]];

        RST = 1'b1; say_ena = 1'b0; say_meth = '0; say_v = '0; heard_rdy = 1'b1;
        for (int a = 0; a < 65536; a++) mem[a] = 17'h0;
        repeat (3) step();
        @(negedge CLK);
        chk("rst_say_rdy", 64'(say_rdy), 64'd0);
        chk("rst_heard_ena", 64'(heard_ena), 64'd0);
        chk("rst_mreq_ena", 64'(mreq_ena), 64'd0);
        chk("rst_mresp_rdy", 64'(mresp_rdy), 64'd0);
        chk("rst_done_count", 64'(done_count), 64'd0);
        chk("rst_heard_meth", 64'(heard_meth), 64'd0);
        step(); RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_say_rdy", 64'(say_rdy), 64'd1);
        step();

        // Single leaf lookup at pass 0 with memory latency 1
        mem[16'h000A] = {1'b1, 16'h0123};
        base = req_addr_q.size();
        send(32'h11, 32'h0A000000, acc);
        wait_heard(1, "single");
        r = got_q.pop_front();
        chk("single_tag", 64'(r.tag), 64'h11);
        chk("single_v", 64'(r.v), 64'h0123);
        chk("single_miss", 64'(r.miss), 64'd0);
        chk("single_latency", 64'(r.cyc - acc), 64'd3);
        chk("single_req_addr", 64'(req_addr_q[base]), 64'h000A);
        chk("single_req_cycle", 64'(req_cyc_q[base] - acc), 64'd1);
        check_done("single_done_count", 1);

        // Directed multi-pass walks
        mem[16'h000A] = {1'b0, 16'h0100};
        mem[16'h0101] = {1'b0, 16'h0200};
        mem[16'h0202] = {1'b1, 16'h0055};
        mem[16'h0020] = {1'b1, 16'h7777};
        mem[16'h0040] = {1'b0, 16'hFFF0};
        mem[16'h0010] = {1'b1, 16'hABCD};
        mem[16'h0050] = {1'b1, 16'h0000};
        mem[16'h0060] = {1'b0, 16'h0300};
        mem[16'h0301] = {1'b0, 16'h0400};
        mem[16'h0402] = {1'b0, 16'h0500};
        mem[16'h0503] = {1'b1, 16'h0BEE};
        tbl[0] = '{32'h21, 32'h0A010203, 16'h0055, 1'b0, 3};
        tbl[1] = '{32'h22, 32'h20FFFFFF, 16'h7777, 1'b0, 1};
        tbl[2] = '{32'h23, 32'h30000000, 16'h0000, 1'b1, 4};
        tbl[3] = '{32'h24, 32'h0A01FF03, 16'h0000, 1'b1, 4};
        tbl[4] = '{32'h25, 32'h40200000, 16'hABCD, 1'b0, 2};
        tbl[5] = '{32'h26, 32'h50123456, 16'h0000, 1'b0, 1};
        tbl[6] = '{32'h27, 32'h60010203, 16'h0BEE, 1'b0, 4};
        for (int i = 0; i < 7; i++) begin
            base = req_addr_q.size();
            send(tbl[i].tag, tbl[i].key, acc);
            wait_heard(1, "tbl");
            repeat (6) step();
            if (got_q.size() > 0) begin
                r = got_q.pop_front();
                chk("tbl_tag", 64'(r.tag), 64'(tbl[i].tag));
                chk("tbl_v", 64'(r.v), 64'(tbl[i].v));
                chk("tbl_miss", 64'(r.miss), 64'(tbl[i].miss));
            end
            chk("tbl_mem_reqs", 64'(req_addr_q.size() - base), 64'(tbl[i].reqs));
        end
        check_done("tbl_done_count", 8);

        // Recirculation collides with a waiting enter: recirc addresses win the port
        base = req_addr_q.size();
        send(32'hA1, 32'h0A010203, acc);
        send(32'hB2, 32'h20FFFFFF, acc);
        wait_heard(2, "collide");
        chk("collide_addr0", 64'(req_addr_q[base]), 64'h000A);
        chk("collide_addr1", 64'(req_addr_q[base + 1]), 64'h0101);
        chk("collide_addr2", 64'(req_addr_q[base + 2]), 64'h0202);
        chk("collide_addr3", 64'(req_addr_q[base + 3]), 64'h0020);
        chk("collide_span", 64'(req_cyc_q[base + 3] - req_cyc_q[base]), 64'd3);
        r = got_q.pop_front();
        chk("collide_first_tag", 64'(r.tag), 64'hA1);
        chk("collide_first_v", 64'(r.v), 64'h0055);
        r = got_q.pop_front();
        chk("collide_second_tag", 64'(r.tag), 64'hB2);
        chk("collide_second_v", 64'(r.v), 64'h7777);
        check_done("collide_done_count", 10);

        // Backpressure: every queue fills, then release in order
        for (int i = 0; i < 14; i++) mem[16'h0080 + 16'(i)] = {1'b1, 16'h1000 + 16'(i)};
        heard_mode = 0;
        repeat (2) step();
        accepted = 0; ok = 1'b1;
        for (int i = 0; i < 14 && ok; i++) begin
            try_send(32'h300 + 32'(i), {8'h80 + 8'(i), 24'h0}, 40, ok);
            if (ok) accepted++;
        end
        @(negedge CLK);
        chk("bp_say_rdy_low", 64'(say_rdy), 64'd0);
        chk("bp_accepted", 64'(accepted), 64'd12);
        chk("bp_no_heard", 64'(got_q.size()), 64'd0);
        step();
        heard_mode = 1;
        for (int i = accepted; i < 14; i++) send(32'h300 + 32'(i), {8'h80 + 8'(i), 24'h0}, acc);
        wait_heard(14, "bp");
        for (int i = 0; i < 14 && got_q.size() > 0; i++) begin
            r = got_q.pop_front();
            chk("bp_order_tag", 64'(r.tag), 64'h300 + 64'(i));
            chk("bp_v", 64'(r.v), 64'h1000 + 64'(i));
        end
        check_done("bp_done_count", 24);

        // Reset with three lookups in flight
        lat_min = 30; lat_max = 30;
        base = req_addr_q.size();
        for (int i = 0; i < 3; i++) send(32'h400 + 32'(i), {8'h80 + 8'(i), 24'h0}, acc);
        for (int t = 0; t < 50 && req_addr_q.size() - base < 3; t++) step();
        chk("rst_mid_inflight", 64'(req_addr_q.size() - base), 64'd3);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_say_rdy", 64'(say_rdy), 64'd0);
        chk("rst_mid_mreq_ena", 64'(mreq_ena), 64'd0);
        chk("rst_mid_mresp_rdy", 64'(mresp_rdy), 64'd0);
        chk("rst_mid_heard_ena", 64'(heard_ena), 64'd0);
        chk("rst_mid_done_count", 64'(done_count), 64'd0);
        step(); step();
        RST = 1'b0;
        saw_late = 1'b0; late_acc = 0; fires0 = resp_fires;
        repeat (40) begin
            @(negedge CLK);
            if (mresp_ena) begin
                saw_late = 1'b1;
                if (mresp_rdy) late_acc++;
            end
        end
        step();
        chk("late_resp_seen", 64'(saw_late), 64'd1);
        chk("late_resp_rdy", 64'(late_acc), 64'd0);
        chk("late_resp_fires", 64'(resp_fires - fires0), 64'd0);
        chk("late_no_heard", 64'(got_q.size()), 64'd0);
        flush_req = 1'b1;
        lat_min = 1; lat_max = 1;
        repeat (2) step();
        send(32'h77, 32'h0A010203, acc);
        wait_heard(1, "after_rst");
        r = got_q.pop_front();
        chk("after_rst_tag", 64'(r.tag), 64'h77);
        chk("after_rst_v", 64'(r.v), 64'h0055);
        chk("after_rst_miss", 64'(r.miss), 64'd0);
        check_done("after_rst_done_count", 1);

        // Random trie, random keys, latency and backpressure, scored by tag
        for (int a = 0; a < 65536; a++)
            mem[a] = {(int'($urandom_range(99, 0)) < 30), 16'($urandom)};
        lat_min = 1; lat_max = 4; mreq_pct = 70; heard_mode = 2;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] key, tag;
            key = $urandom;
            tag = 32'h5000_0000 + 32'(i);
            exp_by_tag[tag] = model(key);
            send(tag, key, acc);
            repeat ($urandom_range(2, 0)) step();
        end
        wait_heard(200, "rand");
        while (got_q.size() > 0) begin
            r = got_q.pop_front();
            if (exp_by_tag.exists(r.tag)) begin
                chk("rand_result", 64'({r.miss, r.v}), 64'(exp_by_tag[r.tag]));
                exp_by_tag.delete(r.tag);
            end else begin
                chk("rand_known_tag", 64'(r.tag), 64'hFFFF_FFFF_FFFF_FFFF);
            end
        end
        chk("rand_all_returned", 64'(exp_by_tag.num()), 64'd0);
        check_done("rand_done_count", 201);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
